cfu_initiator: RTL and testbench

CFU_INITIATOR -- requirements
Module: cfu_initiator

---
 rtl/cfu_initiator.sv | 128 ++++++++++++
 tb/tb_cfu_initiator.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cfu_initiator.sv
// Host-side initiator for a CFU command/response port: one operation in flight.
// Optional watchdog compiled in with `define CFU_INITIATOR_TIMEOUT_EN.
module cfu_initiator #(
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  req_function_id,
  input  logic [31:0] req_inputs_0,
  input  logic [31:0] req_inputs_1,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [31:0] res_data,
  output logic        res_ok,
  output logic        res_timeout,
  output logic        cmd_valid,
  input  logic        cmd_ready,
  output logic [2:0]  cmd_payload_function_id,
  output logic [31:0] cmd_payload_inputs_0,
  output logic [31:0] cmd_payload_inputs_1,
  input  logic        rsp_valid,
  output logic        rsp_ready,
  input  logic        rsp_payload_response_ok,
  input  logic [31:0] rsp_payload_outputs_0,
  output logic        busy
);

  if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 65535) begin : g_param_check
    $error("cfu_initiator: TIMEOUT_CYCLES out of range 2..65535");
  end

  typedef enum logic [1:0] {S_IDLE, S_CMD, S_RSP, S_DONE} state_t;

  state_t      r_state, w_state_nxt;
  logic [2:0]  r_fid;
  logic [31:0] r_in0, r_in1, r_res_data;
  logic        r_res_ok;
  logic        w_accept, w_capture, w_expire;

  assign w_accept  = (r_state == S_IDLE) && req_valid;
  // A response only counts once the command itself has been handshaken.
  assign w_capture = ((r_state == S_CMD) && cmd_ready && rsp_valid) ||
                     ((r_state == S_RSP) && rsp_valid);

`ifdef CFU_INITIATOR_TIMEOUT_EN
  logic [15:0] r_cnt;
  logic        r_res_timeout;

  // Counter equals cycles spent since CMD entry; expiring at N-1 puts DONE exactly N cycles later.
  assign w_expire = ((r_state == S_CMD) || (r_state == S_RSP)) &&
                    (r_cnt == 16'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt         <= '0;
      r_res_timeout <= 1'b0;
    end else begin
      if (w_accept)
        r_cnt <= '0;
      else if ((r_state == S_CMD) || (r_state == S_RSP))
        r_cnt <= r_cnt + 16'd1;
      if (w_capture)
        r_res_timeout <= 1'b0;
      else if (w_expire)
        r_res_timeout <= 1'b1;
    end
  end

  assign res_timeout = r_res_timeout;
`else
  assign w_expire    = 1'b0;
  assign res_timeout = 1'b0;
`endif

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (req_valid) w_state_nxt = S_CMD;
      S_CMD: begin
        if (w_capture)      w_state_nxt = S_DONE;
        else if (w_expire)  w_state_nxt = S_DONE;
        else if (cmd_ready) w_state_nxt = S_RSP;
      end
      S_RSP:  if (w_capture || w_expire) w_state_nxt = S_DONE;
      S_DONE: if (res_ready) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_fid      <= '0;
      r_in0      <= '0;
      r_in1      <= '0;
      r_res_data <= '0;
      r_res_ok   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_fid <= req_function_id;
        r_in0 <= req_inputs_0;
        r_in1 <= req_inputs_1;
      end
      if (w_capture) begin
        r_res_data <= rsp_payload_outputs_0;
        r_res_ok   <= rsp_payload_response_ok;
      end else if (w_expire) begin
        r_res_data <= '0;
        r_res_ok   <= 1'b0;
      end
    end
  end

  assign req_ready               = (r_state == S_IDLE);
  assign busy                    = (r_state != S_IDLE);
  assign cmd_valid               = (r_state == S_CMD);
  assign rsp_ready               = (r_state == S_CMD) || (r_state == S_RSP);
  assign res_valid               = (r_state == S_DONE);
  assign res_data                = r_res_data;
  assign res_ok                  = r_res_ok;
  assign cmd_payload_function_id = r_fid;
  assign cmd_payload_inputs_0    = r_in0;
  assign cmd_payload_inputs_1    = r_in1;

endmodule

// File: tb/tb_cfu_initiator.sv
// Scoreboard bench for cfu_initiator; timeout scenario depends on CFU_INITIATOR_TIMEOUT_EN.
module tb_cfu_initiator;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready;
  logic [2:0]  req_function_id;
  logic [31:0] req_inputs_0, req_inputs_1;
  logic        res_valid, res_ready;
  logic [31:0] res_data;
  logic        res_ok, res_timeout;
  logic        cmd_valid, cmd_ready;
  logic [2:0]  cmd_payload_function_id;
  logic [31:0] cmd_payload_inputs_0, cmd_payload_inputs_1;
  logic        rsp_valid, rsp_ready, rsp_payload_response_ok;
  logic [31:0] rsp_payload_outputs_0;
  logic        busy;

  logic        cfu_comb, m_cmd_ready, m_rsp_valid, m_ok;
  logic [31:0] m_data;

  typedef struct {
    logic [31:0] data;
    logic        ok;
    logic        to;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  cfu_initiator #(.TIMEOUT_CYCLES(8)) dut (
    .clk                     (clk),
    .reset                   (reset),
    .req_valid               (req_valid),
    .req_ready               (req_ready),
    .req_function_id         (req_function_id),
    .req_inputs_0            (req_inputs_0),
    .req_inputs_1            (req_inputs_1),
    .res_valid               (res_valid),
    .res_ready               (res_ready),
    .res_data                (res_data),
    .res_ok                  (res_ok),
    .res_timeout             (res_timeout),
    .cmd_valid               (cmd_valid),
    .cmd_ready               (cmd_ready),
    .cmd_payload_function_id (cmd_payload_function_id),
    .cmd_payload_inputs_0    (cmd_payload_inputs_0),
    .cmd_payload_inputs_1    (cmd_payload_inputs_1),
    .rsp_valid               (rsp_valid),
    .rsp_ready               (rsp_ready),
    .rsp_payload_response_ok (rsp_payload_response_ok),
    .rsp_payload_outputs_0   (rsp_payload_outputs_0),
    .busy                    (busy)
  );

  // CFU model: either zero-wait combinational, or scripted by the stimulus.
  always_comb begin
    if (cfu_comb) begin
      cmd_ready               = rsp_ready;
      rsp_valid               = cmd_valid;
      rsp_payload_response_ok = 1'b1;
      rsp_payload_outputs_0   = cmd_payload_function_id[0] ? cmd_payload_inputs_1
                                                           : cmd_payload_inputs_0;
    end else begin
      cmd_ready               = m_cmd_ready;
      rsp_valid               = m_rsp_valid;
      rsp_payload_response_ok = m_ok;
      rsp_payload_outputs_0   = m_data;
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_req(input logic [2:0] fid, input logic [31:0] in0, input logic [31:0] in1);
    req_valid       = 1'b1;
    req_function_id = fid;
    req_inputs_0    = in0;
    req_inputs_1    = in1;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!reset && res_valid && res_ready) begin
      if (sb.size() == 0) begin
        check("unexpected_res", 1, 0);
      end else begin
        e = sb.pop_front();
        check("res_data", res_data, e.data);
        check("res_ok", res_ok, e.ok);
        check("res_timeout", res_timeout, e.to);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    reset = 1'b1;
    req_valid = 1'b0; req_function_id = '0; req_inputs_0 = '0; req_inputs_1 = '0;
    res_ready = 1'b1;
    cfu_comb = 1'b1; m_cmd_ready = 1'b0; m_rsp_valid = 1'b0; m_ok = 1'b0; m_data = '0;
    repeat (2) tick();

    check("rst_req_ready", req_ready, 1);
    check("rst_cmd_valid", cmd_valid, 0);
    check("rst_rsp_ready", rsp_ready, 0);
    check("rst_res_valid", res_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_res_data", res_data, 0);
    check("rst_res_ok", res_ok, 0);
    check("rst_res_timeout", res_timeout, 0);
    check("rst_fid", cmd_payload_function_id, 0);
    check("rst_in0", cmd_payload_inputs_0, 0);
    check("rst_in1", cmd_payload_inputs_1, 0);
    reset = 1'b0;
    tick();

    // Zero-wait combinational CFU.
    drive_req(3'd1, 32'h11111111, 32'h22222222);
    sb.push_back('{32'h22222222, 1'b1, 1'b0});
    tick();
    req_valid = 1'b0;
    check("comb_cmd_valid", cmd_valid, 1);
    check("comb_fid", cmd_payload_function_id, 1);
    check("comb_in0", cmd_payload_inputs_0, 32'h11111111);
    check("comb_in1", cmd_payload_inputs_1, 32'h22222222);
    tick();
    check("comb_latency", res_valid, 1);
    check("comb_req_ready_done", req_ready, 0);
    tick();
    check("comb_back_idle", req_ready, 1);
    check("comb_busy_idle", busy, 0);

    // Stalled command, ignored early response, delayed response.
    cfu_comb = 1'b0;
    drive_req(3'd6, 32'hA5A5A5A5, 32'h5A5A5A5A);
    sb.push_back('{32'hDEADBEEF, 1'b0, 1'b0});
    tick();
    req_valid = 1'b0;
    drive_req(3'd0, 32'hFFFFFFFF, 32'h0);
    req_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      check("stall_cmd_valid", cmd_valid, 1);
      check("stall_fid", cmd_payload_function_id, 6);
      check("stall_in0", cmd_payload_inputs_0, 32'hA5A5A5A5);
      check("stall_in1", cmd_payload_inputs_1, 32'h5A5A5A5A);
      m_rsp_valid = (k == 1);
      m_data      = 32'h0BAD0BAD;
      m_ok        = 1'b1;
      m_cmd_ready = (k == 3);
      if (k == 3) m_rsp_valid = 1'b0;
      tick();
    end
    m_cmd_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      check("rsp_cmd_valid", cmd_valid, 0);
      check("rsp_rsp_ready", rsp_ready, 1);
      check("rsp_res_valid", res_valid, 0);
      tick();
    end
    m_rsp_valid = 1'b1; m_data = 32'hDEADBEEF; m_ok = 1'b0;
    tick();
    m_rsp_valid = 1'b0; m_data = '0;
    check("late_res_valid", res_valid, 1);
    check("late_rsp_ready", rsp_ready, 0);
    check("late_cmd_valid", cmd_valid, 0);
    tick();
    check("late_idle", req_ready, 1);

    // Result held in DONE while a new request waits.
    cfu_comb = 1'b1; res_ready = 1'b0;
    drive_req(3'd0, 32'h13572468, 32'h9ABCDEF0);
    sb.push_back('{32'h13572468, 1'b1, 1'b0});
    tick();
    drive_req(3'd1, 32'h0BADF00D, 32'hCAFEF00D);
    tick();
    for (int k = 0; k < 5; k++) begin
      check("hold_res_valid", res_valid, 1);
      check("hold_res_data", res_data, 32'h13572468);
      check("hold_res_ok", res_ok, 1);
      check("hold_req_ready", req_ready, 0);
      tick();
    end
    res_ready = 1'b1;
    sb.push_back('{32'hCAFEF00D, 1'b1, 1'b0});
    tick();
    check("hold_idle_ready", req_ready, 1);
    check("hold_idle_busy", busy, 0);
    tick();
    req_valid = 1'b0;
    check("hold_next_cmd", cmd_valid, 1);
    check("hold_next_in1", cmd_payload_inputs_1, 32'hCAFEF00D);
    tick();
    check("hold_next_done", res_valid, 1);
    tick();

    // Asynchronous reset while waiting in RSP.
    cfu_comb = 1'b0; m_cmd_ready = 1'b1; m_rsp_valid = 1'b0;
    drive_req(3'd2, 32'h1, 32'h2);
    tick();
    req_valid = 1'b0;
    tick();
    m_cmd_ready = 1'b0;
    check("ar_rsp_ready", rsp_ready, 1);
    check("ar_cmd_valid", cmd_valid, 0);
    #2 reset = 1'b1;
    #1;
    check("ar_cmd_valid_rst", cmd_valid, 0);
    check("ar_rsp_ready_rst", rsp_ready, 0);
    check("ar_res_valid_rst", res_valid, 0);
    check("ar_busy_rst", busy, 0);
    check("ar_req_ready_rst", req_ready, 1);
    tick();
    reset = 1'b0;
    m_rsp_valid = 1'b1; m_data = 32'h77777777; m_ok = 1'b1;
    tick();
    tick();
    check("ar_stale_rsp", res_valid, 0);
    check("ar_stale_busy", busy, 0);
    m_rsp_valid = 1'b0;
    cfu_comb = 1'b1;
    drive_req(3'd1, 32'h31415926, 32'h27182818);
    sb.push_back('{32'h27182818, 1'b1, 1'b0});
    tick();
    req_valid = 1'b0;
    tick();
    check("ar_recover", res_valid, 1);
    tick();

    // Unresponsive CFU.
    cfu_comb = 1'b0; m_cmd_ready = 1'b0; m_rsp_valid = 1'b0;
    drive_req(3'd5, 32'h12345678, 32'h9);
`ifdef CFU_INITIATOR_TIMEOUT_EN
    sb.push_back('{32'h0, 1'b0, 1'b1});
    tick();
    req_valid = 1'b0;
    n = 0;
    while (!res_valid && n < 20) begin
      tick();
      n++;
    end
    check("to_latency", n, 8);
    check("to_flag", res_timeout, 1);
    tick();
    check("to_idle", req_ready, 1);
`else
    tick();
    req_valid = 1'b0;
    repeat (20) tick();
    check("nt_res_valid", res_valid, 0);
    check("nt_busy", busy, 1);
    check("nt_res_timeout", res_timeout, 0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
`endif

    tick();
    check("sb_empty", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
